// File: rtl/mem_arb_pkg.sv
// Shared types for the BRAM burst-port arbiter: FSM states and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY0   = 2'd1,
    BUSY1   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a contested request
// goes to the port that was not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] pick
);

  // One-hot winner selection
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (last_gnt == PORT_DCACHE) ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one BRAM burst port between icache (port 0) and dcache (port 1),
// locking the grant per burst with a beat watchdog against a stuck BRAM.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned WDOG_SLACK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [1:0]            rw,
  input  logic [DATA_WIDTH-1:0] write0,
  input  logic [DATA_WIDTH-1:0] write1,
  output logic [DATA_WIDTH-1:0] read,
  output logic [1:0]            read_valid,
  output logic [1:0]            write_req,
  output logic [1:0]            last,
  output logic [1:0]            grant,
  output logic                  wdog_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req_op,
  output logic                  mem_rw,
  input  logic [DATA_WIDTH-1:0] mem_read,
  input  logic                  mem_read_valid,
  output logic [DATA_WIDTH-1:0] mem_write,
  input  logic                  mem_write_req_input,
  input  logic                  mem_last
);

  localparam int unsigned WDOG_LIMIT = BURST_LEN + WDOG_SLACK;
  localparam int unsigned CNT_W      = $clog2(WDOG_LIMIT + 1);

  arb_state_e            state_r, state_s;
  logic [1:0]            grant_s;
  logic                  req_op_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic                  rw_s;
  logic                  last_gnt_r, last_gnt_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  wdog_s;
  logic                  busy_s;
  logic                  wdog_hit_s;
  logic [1:0]            pick_s;

  rr_pick2 u_pick (
    .req      (req_op),
    .last_gnt (last_gnt_r),
    .pick     (pick_s)
  );

  assign busy_s     = (state_r == BUSY0) || (state_r == BUSY1);
  assign wdog_hit_s = busy_s && (cnt_r == CNT_W'(WDOG_LIMIT));
  assign read       = mem_read;

  // Next-state and registered-output computation
  always_comb begin
    state_s    = state_r;
    grant_s    = grant;
    req_op_s   = mem_req_op;
    addr_s     = mem_addr;
    rw_s       = mem_rw;
    last_gnt_s = last_gnt_r;
    cnt_s      = cnt_r;
    wdog_s     = wdog_err;
    case (state_r)
      IDLE: begin
        if (pick_s != 2'b00) begin
          grant_s  = pick_s;
          req_op_s = 1'b1;
          cnt_s    = '0;
          if (pick_s[PORT_DCACHE]) begin
            addr_s  = addr1;
            rw_s    = rw[1];
            state_s = BUSY1;
          end else begin
            addr_s  = addr0;
            rw_s    = rw[0];
            state_s = BUSY0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY0, BUSY1: begin
        // A real mem_last wins over a simultaneous expiry: no error then
        if (mem_last || wdog_hit_s) begin
          state_s    = RELEASE;
          grant_s    = 2'b00;
          req_op_s   = 1'b0;
          last_gnt_s = (state_r == BUSY1) ? PORT_DCACHE : PORT_ICACHE;
          if (!mem_last) begin
            wdog_s = 1'b1;
          end else begin
            wdog_s = wdog_err;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_s = IDLE;
      end
      default: begin
        state_s  = IDLE;
        grant_s  = 2'b00;
        req_op_s = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered BRAM request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      grant      <= 2'b00;
      mem_req_op <= 1'b0;
      mem_addr   <= '0;
      mem_rw     <= 1'b0;
      last_gnt_r <= PORT_ICACHE;
      cnt_r      <= '0;
      wdog_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant      <= grant_s;
      mem_req_op <= req_op_s;
      mem_addr   <= addr_s;
      mem_rw     <= rw_s;
      last_gnt_r <= last_gnt_s;
      cnt_r      <= cnt_s;
      wdog_err   <= wdog_s;
    end
  end

  // Zero-latency routing of BRAM handshakes to the current owner only
  always_comb begin
    read_valid = 2'b00;
    write_req  = 2'b00;
    last       = 2'b00;
    mem_write  = '0;
    case (state_r)
      BUSY0: begin
        read_valid = {1'b0, mem_read_valid};
        write_req  = {1'b0, mem_write_req_input};
        last       = {1'b0, mem_last | wdog_hit_s};
        mem_write  = write0;
      end
      BUSY1: begin
        read_valid = {mem_read_valid, 1'b0};
        write_req  = {mem_write_req_input, 1'b0};
        last       = {mem_last | wdog_hit_s, 1'b0};
        mem_write  = write1;
      end
      default: begin
        read_valid = 2'b00;
        write_req  = 2'b00;
        last       = 2'b00;
        mem_write  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and burst
// completions, a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_op;
  logic [15:0] addr0, addr1;
  logic [1:0]  rw;
  logic [31:0] write0, write1;
  logic [31:0] read;
  logic [1:0]  read_valid, write_req, last, grant;
  logic        wdog_err;
  logic [15:0] mem_addr;
  logic        mem_req_op, mem_rw;
  logic [31:0] mem_read;
  logic        mem_read_valid;
  logic [31:0] mem_write;
  logic        mem_write_req_input;
  logic        mem_last;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_op(req_op), .addr0(addr0), .addr1(addr1),
    .rw(rw), .write0(write0), .write1(write1), .read(read),
    .read_valid(read_valid), .write_req(write_req), .last(last), .grant(grant),
    .wdog_err(wdog_err), .mem_addr(mem_addr), .mem_req_op(mem_req_op),
    .mem_rw(mem_rw), .mem_read(mem_read), .mem_read_valid(mem_read_valid),
    .mem_write(mem_write), .mem_write_req_input(mem_write_req_input),
    .mem_last(mem_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  g;
    logic [15:0] a;
    logic        rw;
  } gnt_t;

  typedef struct packed {
    logic [1:0] l;
    int         busy;
    int         beats;
  } done_t;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  int    vec_cnt = 0;
  int    err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each new grant and on each burst end
  logic [1:0] prev_grant = 2'b00;
  int         busy_n = 0;
  int         beat_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = 2'b00;
      busy_n     = 0;
      beat_n     = 0;
    end else begin
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", {62'd0, grant}, 64'd0);
        end else begin
          gnt_t e;
          e = gnt_q.pop_front();
          chk("grant", {62'd0, grant}, {62'd0, e.g});
          chk("mem_addr", {48'd0, mem_addr}, {48'd0, e.a});
          chk("mem_rw", {63'd0, mem_rw}, {63'd0, e.rw});
        end
      end
      if (grant != 2'b00) busy_n++;
      if ((read_valid | write_req) != 2'b00) begin
        beat_n++;
        chk("gate_owner", {62'd0, read_valid | write_req}, {62'd0, grant & (read_valid | write_req)});
      end
      if (last != 2'b00) begin
        if (done_q.size() == 0) begin
          chk("unexpected_last", {62'd0, last}, 64'd0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("last_port", {62'd0, last}, {62'd0, d.l});
          chk("busy_cycles", 64'(busy_n), 64'(d.busy));
          chk("beats", 64'(beat_n), 64'(d.beats));
        end
        busy_n = 0;
        beat_n = 0;
      end
      prev_grant = grant;
    end
  end

  // BRAM model: wait for the request, then serve nbeats cycles
  task automatic do_burst(input int nbeats, input bit wr, input bit with_last, output int waited);
    waited = 0;
    while (mem_req_op !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("req_timeout", {63'd0, mem_req_op}, 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      mem_read_valid      = !wr;
      mem_write_req_input = wr && (i % 2 == 0);
      mem_read            = 32'hA000_0000 + 32'(i);
      mem_last            = with_last && (i == nbeats - 1);
      if (wr) begin
        #1;
        chk("wr_data", {32'd0, mem_write}, {32'd0, 32'hDEAD_BEEF});
        chk("wr_gate", {62'd0, write_req}, {62'd0, mem_write_req_input, 1'b0});
      end
      @(posedge clk); #1;
    end
    mem_read_valid      = 1'b0;
    mem_write_req_input = 1'b0;
    mem_last            = 1'b0;
  endtask

  task automatic push(input logic [1:0] g, input logic [15:0] a, input logic r,
                      input int busy, input int beats);
    gnt_q.push_back('{g: g, a: a, rw: r});
    done_q.push_back('{l: g, busy: busy, beats: beats});
  endtask

  initial begin
    int w;
    int n;
    rst_n = 1'b0; req_op = 2'b00; addr0 = 16'h0; addr1 = 16'h0; rw = 2'b00;
    write0 = 32'h1234_5678; write1 = 32'hDEAD_BEEF; mem_read = 32'h0;
    mem_read_valid = 1'b1; mem_write_req_input = 1'b1; mem_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_req_op", {63'd0, mem_req_op}, 64'd0);
    chk("rst_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_wdog", {63'd0, wdog_err}, 64'd0);
    chk("rst_gated", {58'd0, read_valid, write_req, last}, 64'd0);
    mem_read_valid = 1'b0; mem_write_req_input = 1'b0; mem_last = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single icache fill
    addr0 = 16'h0120; rw = 2'b00; req_op = 2'b01;
    push(2'b01, 16'h0120, 1'b0, 32, 32);
    do_burst(32, 1'b0, 1'b1, w);
    chk("grant_latency", 64'(w), 64'd1);
    req_op = 2'b00;
    chk("req_op_drop", {63'd0, mem_req_op}, 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // Contention from reset: dcache first, then icache after 2 idle cycles
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;
    addr0 = 16'h0200; addr1 = 16'h0300; req_op = 2'b11;
    push(2'b10, 16'h0300, 1'b0, 32, 32);
    push(2'b01, 16'h0200, 1'b0, 32, 32);
    do_burst(32, 1'b0, 1'b1, w);
    req_op = 2'b01;
    do_burst(32, 1'b0, 1'b1, w);
    chk("turnaround", 64'(w), 64'd2);

    // Fairness: both held for 4 bursts
    addr0 = 16'h0400; addr1 = 16'h0500; req_op = 2'b11;
    push(2'b10, 16'h0500, 1'b0, 4, 4);
    push(2'b01, 16'h0400, 1'b0, 4, 4);
    push(2'b10, 16'h0500, 1'b0, 4, 4);
    push(2'b01, 16'h0400, 1'b0, 4, 4);
    for (int b = 0; b < 4; b++) begin
      do_burst(4, 1'b0, 1'b1, w);
      chk("fair_gap", 64'(w), 64'd2);
    end
    req_op = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // dcache write-back, write strobe toggling
    addr1 = 16'h0600; rw = 2'b10; req_op = 2'b10;
    push(2'b10, 16'h0600, 1'b1, 8, 4);
    do_burst(8, 1'b1, 1'b1, w);
    req_op = 2'b00; rw = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Watchdog: no mem_last; last[0] fires after 40 full BUSY cycles (41st)
    addr0 = 16'h0700; req_op = 2'b01;
    push(2'b01, 16'h0700, 1'b0, 41, 0);
    do_burst(0, 1'b0, 1'b0, w);
    n = 0;
    while (grant != 2'b00 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    req_op = 2'b00;
    chk("wdog_err_set", {63'd0, wdog_err}, 64'd1);
    @(posedge clk); #1;
    chk("wdog_idle", {61'd0, grant, mem_req_op}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wdog_sticky", {63'd0, wdog_err}, 64'd1);

    // Reset mid-burst at beat 10
    rst_n = 1'b0; #1; rst_n = 1'b1;
    chk("wdog_cleared", {63'd0, wdog_err}, 64'd0);
    @(posedge clk); #1;
    addr0 = 16'h0800; req_op = 2'b01;
    gnt_q.push_back('{g: 2'b01, a: 16'h0800, rw: 1'b0});
    do_burst(9, 1'b0, 1'b0, w);
    mem_read_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_op", {63'd0, mem_req_op}, 64'd0);
    chk("mid_rst_grant", {62'd0, grant}, 64'd0);
    chk("mid_rst_rvalid", {62'd0, read_valid}, 64'd0);
    @(posedge clk); #1;
    mem_read_valid = 1'b0; req_op = 2'b00; rst_n = 1'b1;
    @(posedge clk); #1;
    addr1 = 16'h0900; req_op = 2'b10;
    push(2'b10, 16'h0900, 1'b0, 4, 4);
    do_burst(4, 1'b0, 1'b1, w);
    chk("post_rst_latency", 64'(w), 64'd1);
    req_op = 2'b00;

    repeat (5) @(posedge clk);
    #1;
    chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
    chk("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
